// File: rtl/wb_port_arbiter.sv
// Single regfile write-port arbiter: in-order pipeline writeback vs. out-of-order MDU result.
// Pipeline has priority, an aging counter forces a starved MDU result, and the winning write is registered.
module wb_port_arbiter #(
    parameter int CPU_WIDTH  = 64,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_rd_wen,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_idx,
    input  logic [CPU_WIDTH-1:0]  i_wb_data,
    output logic                  o_wb_ready,
    input  logic                  i_mdu_valid,
    input  logic [REG_ADDR_W-1:0] i_mdu_rd_idx,
    input  logic [CPU_WIDTH-1:0]  i_mdu_data,
    output logic                  o_mdu_ready,
    output logic                  o_rf_wen,
    output logic [REG_ADDR_W-1:0] o_rf_idx,
    output logic [CPU_WIDTH-1:0]  o_rf_data,
    output logic                  o_dbg_state
);

    // Handshake: a transfer happens on any cycle where valid & ready are both 1; the
    // requester holds idx/data stable until then, and readies never depend on data.

    typedef enum logic [0:0] {S_PIPE = 1'b0, S_FORCE = 1'b1} state_e;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [REG_ADDR_W-1:0] rf_idx_q, rf_idx_d;
    logic [CPU_WIDTH-1:0]  rf_data_q, rf_data_d;

    logic wb_need, mdu_need, waw;
    logic wb_rdy, mdu_rdy, wb_win, mdu_win;

    always_comb begin
        wb_need  = i_wb_valid & i_wb_rd_wen & (i_wb_rd_idx != '0);
        mdu_need = i_mdu_valid & (i_mdu_rd_idx != '0);
        waw      = wb_need & mdu_need & (i_wb_rd_idx == i_mdu_rd_idx);

        wb_rdy  = 1'b0;
        mdu_rdy = 1'b0;
        wb_win  = 1'b0;
        mdu_win = 1'b0;
        state_d = state_q;

        if (!i_rst_n) begin
            state_d = S_PIPE;
        end else if (waw) begin
            // The pipeline write is younger, so the MDU result is consumed and dropped.
            wb_rdy  = 1'b1;
            mdu_rdy = 1'b1;
            wb_win  = 1'b1;
            state_d = S_PIPE;
        end else begin
            case (state_q)
                S_PIPE: begin
                    if (wb_need) begin
                        wb_rdy  = 1'b1;
                        wb_win  = 1'b1;
                        mdu_rdy = ~mdu_need;
                        if (mdu_need && wait_cnt_q == WAIT_LAST) state_d = S_FORCE;
                    end else begin
                        wb_rdy  = 1'b1;
                        mdu_rdy = 1'b1;
                        mdu_win = mdu_need;
                    end
                end
                S_FORCE: begin
                    mdu_rdy = 1'b1;
                    mdu_win = mdu_need;
                    wb_rdy  = ~wb_need;
                    state_d = S_PIPE;
                end
                default: state_d = S_PIPE;
            endcase
        end

        wait_cnt_d = wait_cnt_q;
        if (!i_mdu_valid || mdu_rdy) begin
            wait_cnt_d = '0;
        end else if (mdu_need && wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        rf_wen_d  = wb_win | mdu_win;
        rf_idx_d  = rf_idx_q;
        rf_data_d = rf_data_q;
        if (wb_win) begin
            rf_idx_d  = i_wb_rd_idx;
            rf_data_d = i_wb_data;
        end else if (mdu_win) begin
            rf_idx_d  = i_mdu_rd_idx;
            rf_data_d = i_mdu_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_PIPE;
            wait_cnt_q <= '0;
            rf_wen_q   <= 1'b0;
            rf_idx_q   <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_wen_q   <= rf_wen_d;
            rf_idx_q   <= rf_idx_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign o_wb_ready  = wb_rdy;
    assign o_mdu_ready = mdu_rdy;
    assign o_rf_wen    = rf_wen_q;
    assign o_rf_idx    = rf_idx_q;
    assign o_rf_data   = rf_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: drivers push expected regfile writes, a monitor pops and compares them.
module tb_wb_port_arbiter;

  localparam int CPU_WIDTH  = 64;
  localparam int REG_ADDR_W = 5;
  localparam int EW         = REG_ADDR_W + CPU_WIDTH;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_wb_valid;
  logic                  i_wb_rd_wen;
  logic [REG_ADDR_W-1:0] i_wb_rd_idx;
  logic [CPU_WIDTH-1:0]  i_wb_data;
  logic                  o_wb_ready;
  logic                  i_mdu_valid;
  logic [REG_ADDR_W-1:0] i_mdu_rd_idx;
  logic [CPU_WIDTH-1:0]  i_mdu_data;
  logic                  o_mdu_ready;
  logic                  o_rf_wen;
  logic [REG_ADDR_W-1:0] o_rf_idx;
  logic [CPU_WIDTH-1:0]  o_rf_data;
  logic                  o_dbg_state;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  wb_port_arbiter #(.CPU_WIDTH(CPU_WIDTH), .REG_ADDR_W(REG_ADDR_W), .MAX_WAIT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wb_valid(i_wb_valid), .i_wb_rd_wen(i_wb_rd_wen), .i_wb_rd_idx(i_wb_rd_idx),
    .i_wb_data(i_wb_data), .o_wb_ready(o_wb_ready),
    .i_mdu_valid(i_mdu_valid), .i_mdu_rd_idx(i_mdu_rd_idx), .i_mdu_data(i_mdu_data),
    .o_mdu_ready(o_mdu_ready),
    .o_rf_wen(o_rf_wen), .o_rf_idx(o_rf_idx), .o_rf_data(o_rf_data),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [CPU_WIDTH-1:0] got, input logic [CPU_WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, got, want);
    end
  endtask

  // driver: one cycle of stimulus, checks the combinational readies and queues the expected write
  task automatic drive(input logic wv, input logic wen, input logic [REG_ADDR_W-1:0] widx,
                       input logic [CPU_WIDTH-1:0] wdata, input logic mv,
                       input logic [REG_ADDR_W-1:0] midx, input logic [CPU_WIDTH-1:0] mdata,
                       input logic exp_wrdy, input logic exp_mrdy, input logic exp_wr,
                       input logic [REG_ADDR_W-1:0] exp_idx, input logic [CPU_WIDTH-1:0] exp_data);
    @(negedge i_clk);
    i_wb_valid   = wv;
    i_wb_rd_wen  = wen;
    i_wb_rd_idx  = widx;
    i_wb_data    = wdata;
    i_mdu_valid  = mv;
    i_mdu_rd_idx = midx;
    i_mdu_data   = mdata;
    #1;
    check("wb_ready", CPU_WIDTH'(o_wb_ready), CPU_WIDTH'(exp_wrdy));
    check("mdu_ready", CPU_WIDTH'(o_mdu_ready), CPU_WIDTH'(exp_mrdy));
    if (exp_wr) exp_q.push_back({exp_idx, exp_data});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  // scoreboard monitor: every write must match the head of the queue in the cycle it was due
  always @(posedge i_clk) begin
    #1;
    if (i_rst_n) begin
      if (o_rf_wen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rf_write_unexpected @%0t: got idx=%0d data=0x%0h want no write", $time, o_rf_idx, o_rf_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          checks++;
          if ({o_rf_idx, o_rf_data} !== e) begin
            errors++;
            $display("FAIL rf_write @%0t: got idx=%0d data=0x%0h want idx=%0d data=0x%0h",
                     $time, o_rf_idx, o_rf_data, e[EW-1:CPU_WIDTH], e[CPU_WIDTH-1:0]);
          end
        end
      end else if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rf_write_missing @%0t: got no write want idx=%0d data=0x%0h",
                 $time, e[EW-1:CPU_WIDTH], e[CPU_WIDTH-1:0]);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_wb_valid = 1'b1; i_wb_rd_wen = 1'b1; i_wb_rd_idx = 5'd1; i_wb_data = 64'h1;
    i_mdu_valid = 1'b1; i_mdu_rd_idx = 5'd2; i_mdu_data = 64'h2;
    #1;
    check("reset_wb_ready", CPU_WIDTH'(o_wb_ready), '0);
    check("reset_mdu_ready", CPU_WIDTH'(o_mdu_ready), '0);
    check("reset_rf_wen", CPU_WIDTH'(o_rf_wen), '0);
    repeat (2) @(negedge i_clk);
    i_wb_valid = 1'b0; i_mdu_valid = 1'b0;
    i_rst_n = 1'b1;
    #1;
    check("reset_state", CPU_WIDTH'(o_dbg_state), '0);

    // T2 single writes
    drive(1, 1, 5'd5, 64'h1234, 0, 5'd0, 64'h0, 1, 1, 1, 5'd5, 64'h1234);
    drive(0, 0, 5'd0, 64'h0, 1, 5'd7, 64'hAA, 1, 1, 1, 5'd7, 64'hAA);
    idle();

    // T3 priority, then MDU wins when the pipeline does not write
    drive(1, 1, 5'd3, 64'h33, 1, 5'd9, 64'h99, 1, 0, 1, 5'd3, 64'h33);
    drive(1, 0, 5'd6, 64'h66, 1, 5'd9, 64'h99, 1, 1, 1, 5'd9, 64'h99);
    idle();

    // T4 starvation: four refusals, then a forced MDU write, then WB resumes
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(10 + i), 64'(16'hB000 + i), 1, 5'd9, 64'h5A, 1, 0, 1, 5'(10 + i), 64'(16'hB000 + i));
      check("t4_state_pipe", CPU_WIDTH'(o_dbg_state), '0);
    end
    drive(1, 1, 5'd14, 64'hB004, 1, 5'd9, 64'h5A, 0, 1, 1, 5'd9, 64'h5A);
    check("t4_state_force", CPU_WIDTH'(o_dbg_state), 64'd1);
    drive(1, 1, 5'd14, 64'hB004, 0, 5'd0, 64'h0, 1, 1, 1, 5'd14, 64'hB004);
    check("t4_state_back", CPU_WIDTH'(o_dbg_state), '0);
    idle();

    // T5 WAW: single write of pipeline data
    drive(1, 1, 5'd4, 64'h11, 1, 5'd4, 64'h22, 1, 1, 1, 5'd4, 64'h11);
    idle();

    // T6 x0 requests consume without writing
    drive(1, 1, 5'd0, 64'hDEAD, 1, 5'd0, 64'hBEEF, 1, 1, 0, 5'd0, 64'h0);
    idle();

    // held data across non-writing cycles
    check("hold_idx", CPU_WIDTH'(o_rf_idx), 64'd4);
    check("hold_data", o_rf_data, 64'h11);

    // T1 reset mid-transfer
    drive(1, 1, 5'd8, 64'h88, 1, 5'd8, 64'h99, 1, 1, 1, 5'd8, 64'h88);
    @(posedge i_clk);
    #2;
    check("pre_reset_wen", CPU_WIDTH'(o_rf_wen), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("mid_reset_wen", CPU_WIDTH'(o_rf_wen), '0);
    check("mid_reset_idx", CPU_WIDTH'(o_rf_idx), '0);
    check("mid_reset_data", o_rf_data, '0);
    check("mid_reset_wb_ready", CPU_WIDTH'(o_wb_ready), '0);
    check("mid_reset_mdu_ready", CPU_WIDTH'(o_mdu_ready), '0);
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_wb_valid = 1'b0; i_mdu_valid = 1'b0;
    i_rst_n = 1'b1;
    #1;
    check("post_reset_state", CPU_WIDTH'(o_dbg_state), '0);
    drive(0, 0, 5'd0, 64'h0, 1, 5'd21, 64'hC0DE, 1, 1, 1, 5'd21, 64'hC0DE);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
